// File: rtl/mult8x8_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mult8x8_pkg
// Purpose : Shared widths, FSM states and step schedule for mult8x8_seq.
// Revision: 1.0 - initial release
// ============================================================================
package mult8x8_pkg;

    localparam int DW = 8;
    localparam int NW = 4;
    localparam int PW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] SH0 = 2'b00;
    localparam logic [1:0] SH4 = 2'b01;
    localparam logic [1:0] SH8 = 2'b10;

    typedef struct packed {
        logic       a_hi;
        logic       b_hi;
        logic [1:0] sh;
    } step_sel_t;

    // Step count -> which nibbles to multiply and how far to scale the result.
    function automatic step_sel_t step_sel(input logic [1:0] count);
        step_sel_t s;
        case (count)
            2'd0:    s = '{a_hi: 1'b0, b_hi: 1'b0, sh: SH0};
            2'd1:    s = '{a_hi: 1'b0, b_hi: 1'b1, sh: SH4};
            2'd2:    s = '{a_hi: 1'b1, b_hi: 1'b0, sh: SH4};
            default: s = '{a_hi: 1'b1, b_hi: 1'b1, sh: SH8};
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult8x8_seq_mul4x4.sv
`default_nettype none
// ============================================================================
// Module  : mul4x4
// Purpose : Combinational 4x4 unsigned multiplier with 8-bit product.
// Revision: 1.0 - initial release
// ============================================================================
module mul4x4
    import mult8x8_pkg::*;
(
    input  logic [NW-1:0]   a,
    input  logic [NW-1:0]   b,
    output logic [2*NW-1:0] p
);

    assign p = {{NW{1'b0}}, a} * {{NW{1'b0}}, b};

endmodule
`default_nettype wire

// File: rtl/mult8x8_seq.sv
`default_nettype none
// ============================================================================
// Module  : mult8x8_seq
// Purpose : Sequential 8x8 unsigned multiplier, one nibble pair per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module mult8x8_seq
    import mult8x8_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [DW-1:0] dataa,
    input  logic [DW-1:0] datab,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] product
);

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_count;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   r_product;
    logic            r_busy;
    logic            r_done;

    step_sel_t       w_sel;
    logic [NW-1:0]   w_a_nib;
    logic [NW-1:0]   w_b_nib;
    logic [2*NW-1:0] w_partial;
    logic [PW-1:0]   w_ext;
    logic [PW-1:0]   w_scaled;
    logic [PW-1:0]   w_sum;
    logic            w_accept;
    logic            w_last;

    assign w_sel   = step_sel(r_count);
    assign w_a_nib = w_sel.a_hi ? r_a[DW-1:NW] : r_a[NW-1:0];
    assign w_b_nib = w_sel.b_hi ? r_b[DW-1:NW] : r_b[NW-1:0];

    mul4x4 u_mul4x4 (
        .a (w_a_nib),
        .b (w_b_nib),
        .p (w_partial)
    );

    assign w_ext = {{(PW-2*NW){1'b0}}, w_partial};

    always_comb begin
        w_scaled = w_ext;
        case (w_sel.sh)
            SH4:     w_scaled = w_ext << 4;
            SH8:     w_scaled = w_ext << 8;
            default: w_scaled = w_ext;
        endcase
    end

    // Max result 0xFE01 fits in PW bits, so the plain add never wraps.
    assign w_sum = r_acc + w_scaled;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = CALC;
                end
            end
            CALC: begin
                if (r_count == 2'd3) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = CALC;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_count   <= 2'd0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == CALC);
            r_done  <= (w_next == DONE);
            if (w_accept) begin
                r_a     <= dataa;
                r_b     <= datab;
                r_acc   <= '0;
                r_count <= 2'd0;
            end else if (r_state == CALC) begin
                r_acc   <= w_sum;
                r_count <= r_count + 2'd1;
                if (w_last) begin
                    r_product <= w_sum;
                end
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_mult8x8_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_mult8x8_seq
// Purpose : Directed table-driven bench for mult8x8_seq.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mult8x8_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  dataa = 8'h00;
    logic [7:0]  datab = 8'h00;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] last_prod = 16'h0000;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    mult8x8_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .dataa   (dataa),
        .datab   (datab),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until done is seen (bounded); returns edges taken and busy cycles.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        while (!done && cyc < 12) begin
            if (busy) busy_cnt++;
            if (product !== last_prod) begin
                check("product_hold_in_calc", product, last_prod);
            end
            tick();
            cyc++;
        end
        check("done_seen", done, 1'b1);
    endtask

    // Single operation from IDLE with a one-cycle start pulse.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int cyc;
        int bc;
        dataa = a;
        datab = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        dataa = ~a;
        datab = ~b;
        wait_done(cyc, bc);
        check("latency", cyc, 4);
        check("busy_cycles", bc, 4);
        check("product", product, exp);
        check("busy_low_in_done", busy, 1'b0);
        last_prod = exp;
        tick();
        check("done_one_cycle", done, 1'b0);
        check("product_hold_idle", product, exp);
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) pulses++;
        end
    endtask

    initial begin
        int cyc;
        int bc;
        int pulses;

        vecs[0] = '{8'h12, 8'h34, 16'h03A8};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{8'h00, 8'hA7, 16'h0000};
        vecs[3] = '{8'hA5, 8'h5A, 16'h3A02};
        vecs[4] = '{8'h0F, 8'hF0, 16'h0E10};
        vecs[5] = '{8'h01, 8'h01, 16'h0001};
        vecs[6] = '{8'h80, 8'h02, 16'h0100};
        vecs[7] = '{8'hFF, 8'h01, 16'h00FF};

        // Reset and idle behaviour
        repeat (3) tick();
        check("reset_product", product, 16'h0000);
        check("reset_done", done, 1'b0);
        check("reset_busy", busy, 1'b0);
        reset_n = 1'b1;
        tick();
        check("post_reset_product", product, 16'h0000);
        check("post_reset_busy", busy, 1'b0);
        count_done(10, pulses);
        check("idle_no_done", pulses, 0);
        check("idle_no_busy", busy, 1'b0);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Back-to-back: start held high, second operands taken in the DONE cycle
        dataa = 8'hA5;
        datab = 8'h5A;
        start = 1'b1;
        tick();
        dataa = 8'h0F;
        datab = 8'hF0;
        wait_done(cyc, bc);
        check("b2b_first_latency", cyc, 4);
        check("b2b_first_product", product, 16'h3A02);
        last_prod = 16'h3A02;
        tick();
        start = 1'b0;
        check("b2b_no_idle_busy", busy, 1'b1);
        check("b2b_done_dropped", done, 1'b0);
        check("b2b_product_hold", product, 16'h3A02);
        wait_done(cyc, bc);
        check("b2b_second_latency", cyc, 4);
        check("b2b_second_product", product, 16'h0E10);
        last_prod = 16'h0E10;
        tick();
        check("b2b_end_done", done, 1'b0);

        // Start during CALC is ignored
        dataa = 8'h12;
        datab = 8'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        dataa = 8'hFF;
        datab = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc, bc);
        check("ign_latency", cyc + 3, 4);
        check("ign_product", product, 16'h03A8);
        last_prod = 16'h03A8;
        count_done(8, pulses);
        check("ign_single_done", pulses, 0);

        // Asynchronous reset during count 2
        dataa = 8'hA5;
        datab = 8'h5A;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_product", product, 16'h0000);
        check("areset_busy", busy, 1'b0);
        check("areset_done", done, 1'b0);
        tick();
        reset_n = 1'b1;
        last_prod = 16'h0000;
        count_done(8, pulses);
        check("areset_no_done", pulses, 0);
        check("areset_product_hold", product, 16'h0000);
        run_op(8'h12, 8'h34, 16'h03A8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
